// File: rtl/simon_seg_pkg.sv
// Shared constants, the hex segment table and width helpers for the seven-segment scan driver.
package simon_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment bit 0 is 'a', bit 6 is 'g'; patterns are active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

  function automatic int presc_width(input int scan_div);
    return (scan_div <= 1) ? 1 : $clog2(scan_div);
  endfunction

endpackage

// File: rtl/simon_seg_scan_if.sv
// Game-core side bundle of the scan driver: staging inputs in, segment/digit pads out.
interface simon_seg_scan_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    seg_inv;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig;
  logic                    frame_done;

  modport master (
    output en, load, value, blank, seg_inv,
    input  seg, dig, frame_done
  );

  modport slave (
    input  en, load, value, blank, seg_inv,
    output seg, dig, frame_done
  );
endinterface

// File: rtl/simon_seg_decode.sv
// Combinational nibble-to-segment decoder.
module simon_seg_decode
  import simon_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg(nib_i);
endmodule

// File: rtl/simon_seg_scan.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous value commit.
// Optional leading-zero blanking is enabled by defining SIMON_SEG_LZB_EN.
module simon_seg_scan
  import simon_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int SCAN_DIV    = 1024,
  parameter int DEAD_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  simon_seg_scan_if.slave   bus
);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = presc_width(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] DEAD       = PW'(DEAD_CYCLES);

`ifdef SIMON_SEG_LZB_EN
  // Digit i>0 is suppressed when it and every more-significant nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'h0);
      m[i]       = zero_above;
    end
    return m;
  endfunction
`endif

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                    pend_q, pend_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fd_q, fd_d;

  logic                    slot_end, boundary, blk;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              nib;
  logic [6:0]              dec_seg, pat;

  assign slot_end = bus.en && (presc_q == PRESC_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign onehot   = NUM_DIGITS'(1) << idx_q;
  assign nib      = 4'(act_val_q >> {idx_q, 2'b00});
  assign blk      = |(act_blank_q & onehot);

  simon_seg_decode u_decode (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  assign pat = blk ? SEG_OFF : dec_seg;

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    pend_val_d   = bus.load ? bus.value : pend_val_q;
    pend_blank_d = bus.load ? bus.blank : pend_blank_q;
    pend_d       = pend_q;

    if (!bus.en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (slot_end) begin
      presc_d = '0;
      idx_d   = boundary ? '0 : idx_q + IW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // A load in the boundary cycle bypasses the pending register.
    if (boundary) begin
      pend_d = 1'b0;
      if (bus.load || pend_q) begin
        act_val_d   = bus.load ? bus.value : pend_val_q;
        act_blank_d = bus.load ? bus.blank : pend_blank_q;
`ifdef SIMON_SEG_LZB_EN
        act_blank_d = act_blank_d | lead_zero_mask(act_val_d);
`endif
      end
    end else if (bus.load) begin
      pend_d = 1'b1;
    end

    dig_d = (bus.en && (presc_q >= DEAD)) ? onehot : '0;
    seg_d = (bus.en ? pat : SEG_OFF) ^ {7{bus.seg_inv}};
    fd_d  = boundary;
  end

  always_ff @(posedge wb_clk_i) begin
    pend_val_q   <= pend_val_d;
    pend_blank_q <= pend_blank_d;
    if (wb_rst_i) begin
      presc_q     <= '0;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_blank_q <= '1;
      pend_q      <= 1'b0;
      seg_q       <= SEG_OFF;
      dig_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_simon_seg_scan.sv
// Bench for simon_seg_scan: directed scenarios plus randomized traffic against a frame-position model.
module tb_simon_seg_scan;
  localparam int ND    = 2;
  localparam int SDIV  = 8;
  localparam int DEAD  = 1;
  localparam int FRAME = ND * SDIV;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_seg_scan_if #(.NUM_DIGITS(ND)) ifc ();

  simon_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV), .DEAD_CYCLES(DEAD)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: t counts cycles since the scan (re)started; everything else follows from t mod FRAME.
  int              t;
  logic [4*ND-1:0] mv, pv;
  logic [ND-1:0]   mb, pb;
  bit              pp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [4*ND-1:0] v, input logic [ND-1:0] b);
    bit z;
    mv = v;
    mb = b;
`ifdef SIMON_SEG_LZB_EN
    z = 1'b1;
    for (int i = ND - 1; i > 0; i--) begin
      z = z && (((v >> (4 * i)) & 15) == 0);
      if (z) mb[i] = 1'b1;
    end
`endif
  endtask

  task automatic step();
    logic [6:0]    e_seg;
    logic [ND-1:0] e_dig;
    logic          e_fd;
    int            pos, d, p;
    if (rst) begin
      e_seg = 7'h00; e_dig = '0; e_fd = 1'b0;
      t = 0; mv = '0; mb = '1; pp = 1'b0;
    end else if (!ifc.en) begin
      e_seg = {7{ifc.seg_inv}}; e_dig = '0; e_fd = 1'b0;
      t = 0;
      if (ifc.load) begin pp = 1'b1; pv = ifc.value; pb = ifc.blank; end
    end else begin
      pos   = t % FRAME;
      d     = pos / SDIV;
      p     = pos % SDIV;
      e_dig = (p >= DEAD) ? ND'(1 << d) : '0;
      e_seg = (mb[d] ? 7'h00 : HEX[4'(mv >> (4 * d))]) ^ {7{ifc.seg_inv}};
      e_fd  = (pos == FRAME - 1);
      if (e_fd) begin
        if (ifc.load) commit(ifc.value, ifc.blank);
        else if (pp) commit(pv, pb);
        pp = 1'b0;
      end else if (ifc.load) begin
        pp = 1'b1; pv = ifc.value; pb = ifc.blank;
      end
      t++;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(ifc.seg), 32'(e_seg));
    check("dig", 32'(ifc.dig), 32'(e_dig));
    check("frame_done", 32'(ifc.frame_done), 32'(e_fd));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [4*ND-1:0] v, input logic [ND-1:0] b);
    ifc.load = 1'b1; ifc.value = v; ifc.blank = b;
    step();
    ifc.load = 1'b0;
  endtask

  // Leaves the scan positioned so the next step is frame position 0.
  task automatic wait_frame();
    bit found = 1'b0;
    for (int k = 0; k < 4 * FRAME && !found; k++) begin
      step();
      found = ifc.frame_done;
    end
    check("frame_wait", 32'(found), 32'd1);
  endtask

  initial begin
    ifc.en = 1'b0; ifc.load = 1'b0; ifc.value = '0; ifc.blank = '0; ifc.seg_inv = 1'b0;
    rst = 1'b1;
    steps(3);
    check("rst_seg", 32'(ifc.seg), 32'h00);
    check("rst_dig", 32'(ifc.dig), 32'h0);

    // Free-running scan with nothing loaded: active blank keeps seg dark.
    rst = 1'b0; ifc.en = 1'b1;
    step();
    check("first_dead_dig", 32'(ifc.dig), 32'h0);
    step();
    check("first_dig0", 32'(ifc.dig), 32'h1);
    steps(2 * FRAME);

    // 3A shown after the next boundary.
    load_once(8'h3A, 2'b00);
    wait_frame();
    steps(2);
    check("d0_3A", 32'(ifc.seg), 32'h77);
    steps(8);
    check("d1_3A", 32'(ifc.seg), 32'h4F);
    check("d1_3A_dig", 32'(ifc.dig), 32'h2);

    // Inverted polarity, same value.
    ifc.seg_inv = 1'b1;
    wait_frame();
    steps(2);
    check("d0_3A_inv", 32'(ifc.seg), 32'h08);
    steps(8);
    check("d1_3A_inv", 32'(ifc.seg), 32'h30);
    ifc.seg_inv = 1'b0;

    // Last load before the boundary wins.
    wait_frame();
    steps(10);
    load_once(8'h12, 2'b00);
    step();
    load_once(8'h34, 2'b00);
    wait_frame();
    steps(2);
    check("d0_34", 32'(ifc.seg), 32'h66);
    steps(8);
    check("d1_34", 32'(ifc.seg), 32'h4F);

    // Load coincident with the boundary cycle is visible straight away.
    steps(5);
    load_once(8'h56, 2'b00);
    check("bypass_fd", 32'(ifc.frame_done), 32'd1);
    step();
    check("bypass_d0", 32'(ifc.seg), 32'h7D);

    // Scan disable mid-slot, then restart at digit 0.
    steps(4);
    ifc.en = 1'b0;
    step();
    check("dis_dig", 32'(ifc.dig), 32'h0);
    check("dis_seg", 32'(ifc.seg), 32'h00);
    steps(4);
    ifc.en = 1'b1;
    step();
    check("reen_dead", 32'(ifc.dig), 32'h0);
    step();
    check("reen_dig0", 32'(ifc.dig), 32'h1);

    // Leading zeros.
    load_once(8'h05, 2'b00);
    wait_frame();
    steps(2);
    check("lz05_d0", 32'(ifc.seg), 32'h6D);
    steps(8);
`ifdef SIMON_SEG_LZB_EN
    check("lz05_d1", 32'(ifc.seg), 32'h00);
`else
    check("lz05_d1", 32'(ifc.seg), 32'h3F);
`endif
    load_once(8'h00, 2'b00);
    wait_frame();
    steps(2);
    check("lz00_d0", 32'(ifc.seg), 32'h3F);

    // Randomized traffic including disables, polarity flips and mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (ifc.en) ifc.en = ($urandom_range(0, 59) != 0);
      else        ifc.en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) ifc.seg_inv = ~ifc.seg_inv;
      ifc.load  = ($urandom_range(0, 9) == 0);
      ifc.value = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 15))) : 8'($urandom);
      ifc.blank = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step();
    end
    rst = 1'b0; ifc.load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
